// File: rtl/left_shift_pipe_pkg.sv
// Shared sizing helpers for the left shifter: ceil-log2 and the derived stage count.
package left_shift_pipe_pkg;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // One registered stage per shift-amount bit.
    function automatic int stages_for(input int width);
        return clog2(width);
    endfunction

endpackage

// File: rtl/left_shift_stage.sv
// One register slice of the pipelined left shifter: conditional shift by 2^k, then register.
module left_shift_stage
    import left_shift_pipe_pkg::*;
#(
    parameter  int width  = 8,
    parameter  int k      = 0,
    localparam int STAGES = stages_for(width)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [width-1:0]  in_data,
    input  logic [STAGES-1:0] in_shift,
    input  logic              down_ready,
    output logic              ready,
    output logic              out_valid,
    output logic [width-1:0]  out_data,
    output logic [STAGES-1:0] out_shift
);

    localparam int AMT = 1 << k;

    logic              valid_q, valid_d;
    logic [width-1:0]  data_q,  data_d;
    logic [STAGES-1:0] shift_q, shift_d;
    logic [width-1:0]  shifted;

    assign shifted = in_data << AMT;
    assign ready   = !valid_q || down_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        shift_d = shift_q;
        if (ready) begin
            valid_d = in_valid;
            // Data only moves with a real word so a drained stage keeps its last value.
            if (in_valid) begin
                data_d  = in_shift[k] ? shifted : in_data;
                shift_d = in_shift;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shift_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            shift_q <= shift_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_shift = shift_q;

endmodule

// File: rtl/left_shift_pipe.sv
// Pipelined logarithmic left shifter with valid/ready on both sides and full backpressure.
module left_shift_pipe
    import left_shift_pipe_pkg::*;
#(
    parameter  int width  = 8,
    localparam int STAGES = stages_for(width)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [width-1:0]  i_bits,
    input  logic [STAGES-1:0] shift,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [width-1:0]  o_bits
);

    logic              valid_chain [STAGES+1];
    logic [width-1:0]  data_chain  [STAGES+1];
    logic [STAGES-1:0] shift_chain [STAGES+1];
    logic              ready_chain [STAGES+1];

    assign valid_chain[0]      = i_valid;
    assign data_chain[0]       = i_bits;
    assign shift_chain[0]      = shift;
    assign ready_chain[STAGES] = o_ready;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            left_shift_stage #(
                .width (width),
                .k     (gi)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .in_valid   (valid_chain[gi]),
                .in_data    (data_chain[gi]),
                .in_shift   (shift_chain[gi]),
                .down_ready (ready_chain[gi+1]),
                .ready      (ready_chain[gi]),
                .out_valid  (valid_chain[gi+1]),
                .out_data   (data_chain[gi+1]),
                .out_shift  (shift_chain[gi+1])
            );
        end
    endgenerate

    // Empty stages look ready during reset, so the handshake is masked explicitly.
    assign i_ready = ready_chain[0] && rst;
    assign o_valid = valid_chain[STAGES];
    assign o_bits  = data_chain[STAGES];

endmodule

// File: tb/tb_left_shift_pipe.sv
// Directed bench for left_shift_pipe (width=8) with a queue scoreboard of expected words.
module tb_left_shift_pipe;

    localparam int W  = 8;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          i_ready;
    logic [W-1:0]  i_bits;
    logic [SW-1:0] shift;
    logic          o_valid;
    logic          o_ready;
    logic [W-1:0]  o_bits;

    left_shift_pipe #(.width(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_bits  (i_bits),
        .shift   (shift),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_bits  (o_bits)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
        bit           chk_lat;
    } exp_t;

    exp_t         sb [$];
    int           checks  = 0;
    int           errors  = 0;
    int           cyc     = 0;
    int           out_cnt = 0;
    bit           lat_flag = 1'b0;
    bit           acc;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_bits = '0;

    function automatic logic [W-1:0] model(input logic [W-1:0] b, input int s);
        logic [2*W-1:0] wide;
        if (s >= W) return '0;
        wide = {{W{1'b0}}, b} << s;
        return wide[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] b, input logic [SW-1:0] s, input logic v);
        i_bits  = b;
        shift   = s;
        i_valid = v;
    endtask

    // Sample at the falling edge, then move to just after the next rising edge.
    task automatic tick();
        exp_t e;
        acc = 1'b0;
        @(negedge clk);
        if (prev_stall) begin
            check("hold_valid", 32'(o_valid), 32'd1);
            check("hold_bits", 32'(o_bits), 32'(prev_bits));
        end
        if (rst && i_valid && i_ready) begin
            acc = 1'b1;
            sb.push_back('{model(i_bits, int'(shift)), cyc, lat_flag});
            $display("cyc %0d IN  bits=%02h shift=%0d", cyc, i_bits, shift);
        end
        if (o_valid && o_ready) begin
            out_cnt++;
            $display("cyc %0d OUT bits=%02h", cyc, o_bits);
            if (sb.size() == 0) begin
                check("unexpected_out", 32'(o_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("out_bits", 32'(o_bits), 32'(e.data));
                if (e.chk_lat) check("latency", 32'(cyc - e.cyc), 32'd3);
            end
        end
        prev_stall = o_valid && !o_ready;
        prev_bits  = o_bits;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int n0;
        rst     = 1'b0;
        o_ready = 1'b0;
        drive(8'h00, 3'd0, 1'b0);
        tick();
        tick();
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_bits", 32'(o_bits), 32'd0);
        check("rst_i_ready", 32'(i_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rel_i_ready", 32'(i_ready), 32'd1);

        // 1: single word, unstalled latency
        o_ready  = 1'b1;
        lat_flag = 1'b1;
        drive(8'hB3, 3'd3, 1'b1);
        tick();
        drive(8'h00, 3'd0, 1'b0);
        repeat (4) tick();
        check("t1_drain", 32'(sb.size()), 32'd0);

        // 2: zero shift and maximum shift
        drive(8'hA5, 3'd0, 1'b1);
        tick();
        drive(8'h00, 3'd0, 1'b0);
        repeat (3) tick();
        drive(8'hFF, 3'd7, 1'b1);
        tick();
        drive(8'h00, 3'd0, 1'b0);
        repeat (4) tick();
        check("t2_drain", 32'(sb.size()), 32'd0);

        // 3: back-to-back at full throughput
        drive(8'h01, 3'd1, 1'b1); check("t3_ready0", 32'(i_ready), 32'd1); tick();
        drive(8'h01, 3'd2, 1'b1); check("t3_ready1", 32'(i_ready), 32'd1); tick();
        drive(8'h01, 3'd4, 1'b1); check("t3_ready2", 32'(i_ready), 32'd1); tick();
        drive(8'h0F, 3'd4, 1'b1); check("t3_ready3", 32'(i_ready), 32'd1); tick();
        drive(8'h00, 3'd0, 1'b0);
        repeat (4) tick();
        check("t3_drain", 32'(sb.size()), 32'd0);

        // 4: backpressure fills the pipe, then drains in order
        lat_flag = 1'b0;
        o_ready  = 1'b0;
        n0 = 1;
        for (int c = 0; c < 6; c++) begin
            drive(8'(n0), 3'd1, 1'b1);
            tick();
            if (acc) n0++;
        end
        check("t4_accepted", 32'(sb.size()), 32'd3);
        check("t4_full_ready", 32'(i_ready), 32'd0);
        check("t4_o_valid", 32'(o_valid), 32'd1);
        check("t4_o_bits", 32'(o_bits), 32'h02);
        o_ready = 1'b1;
        #1;
        check("t4_rise_ready", 32'(i_ready), 32'd1);
        n0 = out_cnt;
        drive(8'h04, 3'd1, 1'b1);
        tick();
        drive(8'h05, 3'd1, 1'b1);
        tick();
        drive(8'h00, 3'd0, 1'b0);
        repeat (3) tick();
        check("t4_out_count", 32'(out_cnt - n0), 32'd5);
        check("t4_drain", 32'(sb.size()), 32'd0);

        // 5: bubble collapse behind a held output
        o_ready = 1'b0;
        drive(8'h11, 3'd2, 1'b1);
        tick();
        drive(8'h00, 3'd0, 1'b0);
        tick();
        tick();
        check("t5_head_valid", 32'(o_valid), 32'd1);
        check("t5_head_bits", 32'(o_bits), 32'h44);
        drive(8'h03, 3'd1, 1'b1);
        check("t5_ready_a", 32'(i_ready), 32'd1);
        tick();
        drive(8'h00, 3'd0, 1'b0);
        check("t5_ready_b", 32'(i_ready), 32'd1);
        tick();
        check("t5_ready_c", 32'(i_ready), 32'd1);
        check("t5_still_head", 32'(o_bits), 32'h44);
        o_ready = 1'b1;
        repeat (3) tick();
        check("t5_drain", 32'(sb.size()), 32'd0);

        // 6: asynchronous reset with words in flight
        o_ready = 1'b0;
        drive(8'h21, 3'd1, 1'b1);
        tick();
        drive(8'h22, 3'd1, 1'b1);
        tick();
        drive(8'h00, 3'd0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_o_valid", 32'(o_valid), 32'd0);
        check("t6_rst_i_ready", 32'(i_ready), 32'd0);
        check("t6_rst_o_bits", 32'(o_bits), 32'd0);
        sb.delete();
        prev_stall = 1'b0;
        tick();
        rst     = 1'b1;
        o_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            check("t6_no_stale", 32'(o_valid), 32'd0);
            tick();
        end
        lat_flag = 1'b1;
        drive(8'h81, 3'd1, 1'b1);
        tick();
        drive(8'h00, 3'd0, 1'b0);
        check("t6_post_a", 32'(o_valid), 32'd0);
        tick();
        check("t6_post_b", 32'(o_valid), 32'd0);
        repeat (3) tick();
        check("t6_drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/left_shift_pipe.md
Name: left_shift_pipe

Overview:
Pipelined logarithmic left shifter, the complementary direction to the team's combinational generic right shifter.
- Shifts a width-bit word left by a runtime amount, zero-filling from the LSB.
- Uses clog2(width) registered stages, with valid/ready handshakes on both sides.
- Sits in datapaths where a full-width combinational shift would break timing; full backpressure support.

Parameters:
- width, 8, bit width of input and output words; legal range width >= 2.
- STAGES (derived, not overridable), clog2(width), number of pipeline stages and width of shift.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_valid  in  1  upstream word present.
- i_ready  out  1  block accepts the word this cycle.
- i_bits  in  width  word to shift.
- shift  in  STAGES  left-shift amount, 0..width-1 (values >= width, non-power-of-2 widths: result all zeros).
- o_valid  out  1  shifted word present.
- o_ready  in  1  downstream accepts.
- o_bits  out  width  shifted result.

Behaviour:
- Transfer rules:
  - Input transfer happens when i_valid && i_ready.
  - Output transfer happens when o_valid && o_ready.
  - i_valid/i_bits/shift are sampled only on transfer.
- Stage k (k = 0..STAGES-1) register slice holds: valid_k, data_k, remaining shift bits.
  - Stage k applies a shift of 2^k when shift bit k is set, then registers the result.
  - Stage 0 loads from the inputs; stage STAGES-1 drives o_bits/o_valid.
- Shift amounts >= width: result is 0.
- Per-stage advance: ready_k = !valid_k || ready_(k+1), with ready_STAGES = o_ready.
  - i_ready = ready_0 (combinational).
  - A stage loads when its own ready is high; its valid becomes the upstream transfer condition.
- Latency: exactly STAGES cycles from input transfer to o_valid, when unstalled (width=8: 3 cycles).
- Throughput: one word per cycle when o_ready is held high.
- Bubbles collapse: an empty stage accepts even if downstream is stalled.
- Capacity: STAGES words in flight. With o_ready low and the pipe full, i_ready = 0.
- Output stability: while o_valid && !o_ready, o_bits holds stable.
- Ordering: strict FIFO. No word is dropped or duplicated.
- Simultaneous full pipe + o_ready rising: an input transfer in the same cycle is allowed, since i_ready follows the ready chain combinationally.
- Reset (rst low, asynchronous):
  - All valid_k = 0, all data_k = 0, so o_valid = 0 and o_bits = 0 immediately.
  - i_ready forced 0 while rst is low.
  - Reset mid-operation discards all in-flight words; no stale output after release.
  - First input is accepted on the first rising edge with rst high.
- No combinational path i_valid -> o_valid. The only combinational path is o_ready -> i_ready.

Decomposition:
- Shared package/defs: the clog2 function (the same one used for the right shifter's shift port width) and the STAGES derivation.
- One sub-module, left_shift_stage:
  - Parameters: width, stage index k.
  - Contains: one register slice, the conditional 2^k shift and the local ready computation.
  - left_shift_pipe instantiates it STAGES times in a generate loop.

Test Plan:
1. width=8, i_bits=0xB3, shift=3, o_ready=1 -> o_valid exactly 3 cycles after transfer, o_bits=0x98.
2. i_bits=0xA5, shift=0 -> o_bits=0xA5 after 3 cycles. i_bits=0xFF, shift=7 -> o_bits=0x80.
3. Back-to-back, o_ready=1: (0x01,1), (0x01,2), (0x01,4), (0x0F,4) on 4 consecutive cycles -> 0x02, 0x04, 0x10, 0xF0 on 4 consecutive cycles, i_ready constantly 1.
4. Backpressure: o_ready=0, i_valid=1 continuously, words 0x01..0x05 with shift=1 -> exactly 3 accepted, then i_ready=0 and o_bits held at 0x02. Raise o_ready -> outputs 0x02, 0x04, 0x06, 0x08, 0x0A in order, one per cycle, no loss or duplication.
5. Bubble collapse: one word, o_ready=0 until it reaches the output, then a second word -> second word advances to stage 1 while the first is held. i_ready never drops.
6. Reset mid-operation: 2 words in flight, rst low asynchronously between edges -> o_valid=0 and i_ready=0 immediately. After release, o_valid stays 0 until a new input completes 3 cycles later.
